// File: rtl/hwag_pkg.sv
// Shared constants, sequencer state encoding and modulo-cycle arithmetic
// for the ignition scheduler.
package hwag_pkg;

  localparam int ANGLE_PER_TOOTH = 64;
  localparam int ANGLE_REV       = 3840;
  localparam int ANGLE_CYCLE     = 7680;
  localparam int ADV_MAX         = 1280;
  localparam int DWELL_MAX       = 3840;

  typedef enum logic [1:0] {
    IDLE,
    CALC_FIRE,
    CALC_START,
    WRITE
  } sched_state_t;

  // a - b wrapped into 0..ANGLE_CYCLE-1; both operands are already in range.
  function automatic logic [12:0] sub_mod_cycle(input logic [12:0] a, input logic [12:0] b);
    logic [13:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    if (diff[13]) begin
      diff = diff + 14'(ANGLE_CYCLE);
    end
    return diff[12:0];
  endfunction

endpackage

// File: rtl/hwag_ign_channel.sv
// One ignition channel: pending/active angle sets, safe-point commit,
// start/fire equality compare and the coil drive flop.
module hwag_ign_channel
  import hwag_pkg::*;
#(
  parameter int ANGLE_WIDTH = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hwag_start,
  input  logic [ANGLE_WIDTH-1:0] cyc,
  input  logic                   wr_en,
  input  logic [ANGLE_WIDTH-1:0] wr_start,
  input  logic [ANGLE_WIDTH-1:0] wr_fire,
  input  logic [ANGLE_WIDTH-1:0] wr_dwell,
  output logic                   pending,
  output logic                   ign_out
);

  logic                   pend_q;
  logic [ANGLE_WIDTH-1:0] pend_start_q, pend_fire_q, pend_dwell_q;
  logic [ANGLE_WIDTH-1:0] act_start_q, act_fire_q, act_dwell_q;
  logic                   ign_q, ign_d;
  logic                   act_en, hit_start, hit_fire, fire_edge, commit;

  assign act_en    = hwag_start && (act_dwell_q != '0);
  assign hit_start = act_en && (cyc == act_start_q);
  assign hit_fire  = act_en && (cyc == act_fire_q);
  assign fire_edge = ign_q && hit_fire;

  // Swap in new angles only where no coil event can be lost or doubled.
  assign commit = pend_q && (fire_edge || ((act_dwell_q == '0) && !ign_q) || !hwag_start);

  always_comb begin
    ign_d = ign_q;
    if (!hwag_start) begin
      ign_d = 1'b0;
    end else if (hit_fire) begin
      ign_d = 1'b0;
    end else if (hit_start) begin
      ign_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q       <= 1'b0;
      pend_start_q <= '0;
      pend_fire_q  <= '0;
      pend_dwell_q <= '0;
      act_start_q  <= '0;
      act_fire_q   <= '0;
      act_dwell_q  <= '0;
      ign_q        <= 1'b0;
    end else begin
      ign_q <= ign_d;
      if (commit) begin
        act_start_q <= pend_start_q;
        act_fire_q  <= pend_fire_q;
        act_dwell_q <= pend_dwell_q;
      end
      // A same-cycle write lands after the commit has taken the old values.
      if (wr_en) begin
        pend_q       <= 1'b1;
        pend_start_q <= wr_start;
        pend_fire_q  <= wr_fire;
        pend_dwell_q <= wr_dwell;
      end else if (commit) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign pending = pend_q;
  assign ign_out = ign_q && hwag_start;

endmodule

// File: rtl/hwag_ign_sched.sv
// Ignition scheduler top: config handshake with range check, shared-subtractor
// sequencer and cycle-angle formation feeding the per-channel comparators.
module hwag_ign_sched
  import hwag_pkg::*;
#(
  parameter int ANGLE_WIDTH = 13,
  parameter int CHANNELS    = 4,
  parameter int CH_WIDTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hwag_start,
  input  logic [23:0]            acnt,
  input  logic                   phase,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [CH_WIDTH-1:0]    cfg_ch,
  input  logic [ANGLE_WIDTH-1:0] cfg_tdc,
  input  logic [ANGLE_WIDTH-1:0] cfg_adv,
  input  logic [ANGLE_WIDTH-1:0] cfg_dwell,
  output logic                   cfg_err,
  output logic [CHANNELS-1:0]    pending,
  output logic [CHANNELS-1:0]    ign_out
);

  sched_state_t           state_q, state_d;
  logic                   err_q;
  logic                   accept, reject, cfg_bad;
  logic [CH_WIDTH-1:0]    ch_q;
  logic [ANGLE_WIDTH-1:0] tdc_q, adv_q, dwell_q, fire_q, start_q;
  logic [ANGLE_WIDTH-1:0] sub_a, sub_b, sub_res;
  logic [ANGLE_WIDTH-1:0] cyc;
  logic                   unused_acnt_hi;

  assign cyc            = acnt[ANGLE_WIDTH-1:0] + (phase ? ANGLE_WIDTH'(ANGLE_REV) : '0);
  assign unused_acnt_hi = ^acnt[23:ANGLE_WIDTH];

  assign cfg_bad = (cfg_tdc > ANGLE_WIDTH'(ANGLE_CYCLE - 1)) ||
                   (cfg_adv > ANGLE_WIDTH'(ADV_MAX)) ||
                   (cfg_dwell > ANGLE_WIDTH'(DWELL_MAX));

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_bad) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = CALC_FIRE;
          end
        end
      end
      CALC_FIRE:  state_d = CALC_START;
      CALC_START: state_d = WRITE;
      WRITE:      state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // One subtractor serves both fire = tdc - adv and start = fire - dwell.
  assign sub_a   = (state_q == CALC_FIRE) ? tdc_q : fire_q;
  assign sub_b   = (state_q == CALC_FIRE) ? adv_q : dwell_q;
  assign sub_res = ANGLE_WIDTH'(sub_mod_cycle(13'(sub_a), 13'(sub_b)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      ch_q    <= '0;
      tdc_q   <= '0;
      adv_q   <= '0;
      dwell_q <= '0;
      fire_q  <= '0;
      start_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= reject;
      if (accept) begin
        ch_q    <= cfg_ch;
        tdc_q   <= cfg_tdc;
        adv_q   <= cfg_adv;
        dwell_q <= cfg_dwell;
      end
      if (state_q == CALC_FIRE) begin
        fire_q <= sub_res;
      end
      if (state_q == CALC_START) begin
        start_q <= sub_res;
      end
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign cfg_err   = err_q;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      hwag_ign_channel #(
        .ANGLE_WIDTH(ANGLE_WIDTH)
      ) u_ch (
        .clk       (clk),
        .rst       (rst),
        .hwag_start(hwag_start),
        .cyc       (cyc),
        .wr_en     ((state_q == WRITE) && (ch_q == CH_WIDTH'(gi))),
        .wr_start  (start_q),
        .wr_fire   (fire_q),
        .wr_dwell  (dwell_q),
        .pending   (pending[gi]),
        .ign_out   (ign_out[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_hwag_ign_sched.sv
// Directed bench for the ignition scheduler: handshake, angle arithmetic,
// safe commit, rejection, sync loss and mid-sequence reset.
module tb_hwag_ign_sched;

  logic        clk = 1'b0;
  logic        rst, hwag_start, phase, cfg_valid, cfg_ready, cfg_err;
  logic [23:0] acnt;
  logic [1:0]  cfg_ch;
  logic [12:0] cfg_tdc, cfg_adv, cfg_dwell;
  logic [3:0]  pending, ign_out;

  int n_cmp  = 0;
  int n_bad  = 0;
  int cyc_tb = 0;

  hwag_ign_sched dut (
    .clk       (clk),
    .rst       (rst),
    .hwag_start(hwag_start),
    .acnt      (acnt),
    .phase     (phase),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_tdc   (cfg_tdc),
    .cfg_adv   (cfg_adv),
    .cfg_dwell (cfg_dwell),
    .cfg_err   (cfg_err),
    .pending   (pending),
    .ign_out   (ign_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cyc(input int c);
    cyc_tb = c;
    phase  = (c >= 3840);
    acnt   = 24'((c >= 3840) ? c - 3840 : c);
  endtask

  // Step the crank one angle unit per clock until the target has been sampled.
  task automatic run_to(input int target);
    int guard = 0;
    while (cyc_tb != target && guard < 8000) begin
      set_cyc((cyc_tb + 1) % 7680);
      tick();
      guard++;
    end
  endtask

  task automatic drive_cfg(input logic [1:0] ch, input int tdc, input int adv, input int dwell);
    cfg_ch    = ch;
    cfg_tdc   = 13'(tdc);
    cfg_adv   = 13'(adv);
    cfg_dwell = 13'(dwell);
  endtask

  task automatic send(input logic [1:0] ch, input int tdc, input int adv, input int dwell);
    drive_cfg(ch, tdc, adv, dwell);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hwag_start = 1'b1; cfg_valid = 1'b0;
    drive_cfg(2'd0, 0, 0, 0);
    set_cyc(0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", cfg_ready, 1);
    chk("rst_err", cfg_err, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ign", ign_out, 0);

    // ch0: fire 7040, start 5120
    send(2'd0, 0, 640, 1920);
    chk("ch0_ready_low", cfg_ready, 0);
    tick(); tick();
    chk("ch0_pend_early", pending, 0);
    tick();
    chk("ch0_pend_vis", pending, 4'b0001);
    chk("ch0_ready_back", cfg_ready, 1);
    tick();
    chk("ch0_commit_idle", pending, 0);

    // ch1: fire 7448, start 4448
    send(2'd1, 768, 1000, 3000);
    tick(); tick(); tick();
    chk("ch1_pend_vis", pending, 4'b0010);
    tick();
    chk("ch1_commit_idle", pending, 0);

    run_to(4447); chk("ign_4447", ign_out, 4'b0000);
    run_to(4448); chk("ign_4448", ign_out, 4'b0010);
    run_to(5119); chk("ign_5119", ign_out, 4'b0010);
    run_to(5120); chk("ign_5120", ign_out, 4'b0011);
    run_to(7039); chk("ign_7039", ign_out, 4'b0011);
    run_to(7040); chk("ign_7040", ign_out, 4'b0010);
    run_to(7447); chk("ign_7447", ign_out, 4'b0010);
    run_to(7448); chk("ign_7448", ign_out, 4'b0000);

    // Safe commit: rewrite ch0 mid-dwell (new fire 0, start 5760)
    run_to(5200); chk("sc_ign_5200", ign_out, 4'b0011);
    send(2'd0, 0, 0, 1920);
    tick(); tick(); tick();
    chk("sc_pend_set", pending, 4'b0001);
    tick();
    chk("sc_pend_hold", pending, 4'b0001);
    run_to(7039);
    chk("sc_pend_7039", pending, 4'b0001);
    chk("sc_ign0_7039", ign_out[0], 1);
    run_to(7040);
    chk("sc_pend_7040", pending, 4'b0000);
    chk("sc_ign_7040", ign_out, 4'b0010);
    run_to(5759); chk("sc_ign0_5759", ign_out[0], 0);
    run_to(5760); chk("sc_ign0_5760", ign_out[0], 1);
    run_to(7679); chk("sc_ign0_7679", ign_out[0], 1);
    run_to(0);    chk("sc_ign0_0", ign_out[0], 0);

    // Rejections
    send(2'd2, 0, 1281, 100);
    chk("rej_adv_err", cfg_err, 1);
    chk("rej_adv_ready", cfg_ready, 1);
    tick();
    chk("rej_err_pulse", cfg_err, 0);
    send(2'd2, 0, 0, 3841);
    chk("rej_dwell_err", cfg_err, 1);
    send(2'd2, 7680, 0, 100);
    chk("rej_tdc_err", cfg_err, 1);
    tick(); tick(); tick();
    chk("rej_pending", pending, 0);
    chk("rej_ready", cfg_ready, 1);

    // Boundary accept ch3: fire 6399, start 2559
    send(2'd3, 7679, 1280, 3840);
    chk("bnd_err", cfg_err, 0);
    chk("bnd_ready", cfg_ready, 0);
    tick(); tick(); tick();
    chk("bnd_pend", pending, 4'b1000);
    tick();

    // Back-to-back: A (fire 3840,start 3200) then B (fire 3740,start 3100)
    drive_cfg(2'd2, 3840, 0, 640);
    cfg_valid = 1'b1;
    tick(); chk("hs_ready_t1", cfg_ready, 0);
    drive_cfg(2'd2, 3840, 100, 640);
    tick(); chk("hs_ready_t2", cfg_ready, 0);
    tick(); chk("hs_ready_t3", cfg_ready, 0);
    tick(); chk("hs_ready_t4", cfg_ready, 1);
    tick(); chk("hs_second_acc", cfg_ready, 0);
    cfg_valid = 1'b0;
    chk("hs_a_committed", pending, 0);
    tick(); tick(); tick();
    chk("hs_b_pend", pending, 4'b0100);
    tick();
    chk("hs_b_hold", pending, 4'b0100);

    // Sync loss while ch2 charges under A
    run_to(3200);
    chk("sl_ign_3200", ign_out, 4'b1100);
    hwag_start = 1'b0;
    #1;
    chk("sl_ign_drop", ign_out, 0);
    tick();
    chk("sl_commit", pending, 0);
    hwag_start = 1'b1;
    run_to(3099); chk("sl_b_3099", ign_out[2], 0);
    run_to(3100); chk("sl_b_3100", ign_out[2], 1);
    run_to(3740); chk("sl_b_3740", ign_out[2], 0);
    chk("sl_ch3_3740", ign_out[3], 1);

    // Reset during CALC_START
    send(2'd0, 100, 0, 100);
    tick(); tick(); tick();
    chk("rs_pend_pre", pending, 4'b0001);
    send(2'd1, 0, 0, 100);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_ready", cfg_ready, 1);
    chk("rs_pending", pending, 0);
    chk("rs_ign", ign_out, 0);
    tick(); tick(); tick();
    chk("rs_discarded", pending, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hwag_ign_sched.md
Name: hwag_ign_sched

Overview:
- Ignition scheduler that sits after the angle generator core and the second master angle counter.
- Accepts per-channel TDC, advance and dwell settings through a valid/ready config port.
- A single shared sequencer computes each channel's start and fire angles over the 720° cycle.
- Committed angles are compared against the live cycle angle to drive the coil outputs. New settings take effect only at a safe point, so no coil event is lost or doubled.

Parameters:
- ANGLE_WIDTH, 13: width of cycle-angle arithmetic. The cycle range is 0..7679 at 64 angle units per tooth.
- CHANNELS, 4: number of ignition channels.
- CH_WIDTH, 2: width of the channel index (clog2 of CHANNELS).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- hwag_start  in  1  angle generator synchronised.
- acnt  in  24  crank angle within revolution, 0..3839. Steps by +1 and wraps 3839->0.
- phase  in  1  cam phase: 0 = first revolution, 1 = second revolution.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  sequencer can accept a request.
- cfg_ch  in  CH_WIDTH  target channel.
- cfg_tdc  in  ANGLE_WIDTH  channel TDC cycle angle, 0..7679.
- cfg_adv  in  ANGLE_WIDTH  advance, 0..1280.
- cfg_dwell  in  ANGLE_WIDTH  dwell angle, 0..3840. 0 disables the channel.
- cfg_err  out  1  one-cycle pulse: request rejected.
- pending  out  CHANNELS  per-channel "computed, not yet committed".
- ign_out  out  CHANNELS  coil drive, 1 = charging.

Behaviour:
- Reset and clocking: one clock; reset is synchronous and active-high, on port rst.
  - Reset values: ign_out=0, cfg_ready=1, cfg_err=0, pending=0.
  - All active/pending dwell=0 (channels disabled); all start/fire=0.
- Cycle angle: cyc = acnt[12:0] + (phase ? 3840 : 0). It is combinational and used only when hwag_start=1.
- Config handshake: a request is accepted when cfg_valid & cfg_ready. cfg_ready=1 only in state IDLE.
- Range check at acceptance: reject if tdc>7679, adv>1280 or dwell>3840.
  - Rejection pulses cfg_err for one cycle, stays in IDLE and keeps cfg_ready=1.
  - No register changes on rejection.
- Sequencer FSM, IDLE -> CALC_FIRE -> CALC_START -> WRITE -> IDLE:
  - CALC_FIRE: fire = tdc - adv. If the result is negative, add 7680.
  - CALC_START: start = fire - dwell, with the same modulo-7680 rule.
  - WRITE: load the channel's pending registers (start, fire, dwell) and set pending[ch].
  - pending is visible 3 cycles after acceptance; the next accept is possible 4 cycles after acceptance.
  - A single subtractor is shared by CALC_FIRE and CALC_START.
- Re-write of a channel that is already pending overwrites its pending values and keeps pending=1.
- Output per channel (hwag_start=1, active dwell≠0):
  - ign_out sets when cyc==start.
  - ign_out clears when cyc==fire.
  - Otherwise ign_out holds.
  - Comparisons are equality compares; every angle is visited because acnt steps by 1.
- Commit (pending -> active), when pending=1 and any of the following holds:
  - (a) this cycle ign_out goes 1->0 (fire point);
  - (b) active dwell==0 and ign_out==0;
  - (c) hwag_start==0.
  - On commit, clear pending.
  - If WRITE for the same channel coincides with a commit: the commit uses the pre-WRITE pending values, and the new values stay pending.
- hwag_start=0: all ign_out forced to 0 the same cycle. The FSM continues and config is still accepted.
- hwag_start falling mid-dwell: output drops immediately. There is no fire-edge commit in that case; commit rule (c) applies.
- Committing dwell=0 while ign_out=1 is impossible, because commit happens only at the fire edge or with the output low.
- rst mid-sequence: FSM returns to IDLE, the in-flight request is discarded, and all state returns to reset values.

Decomposition:
- Shared package hwag_pkg holds:
  - ANGLE_PER_TOOTH=64, ANGLE_REV=3840, ANGLE_CYCLE=7680, ADV_MAX=1280, DWELL_MAX=3840;
  - enum sched_state_t {IDLE, CALC_FIRE, CALC_START, WRITE};
  - a mod-7680 subtraction function.
- Sub-module hwag_ign_channel, instantiated CHANNELS times. It holds the pending/active registers, commit logic, compare and ign_out flop.
- The top level holds the FSM, range check, shared subtractor and cycle-angle formation.

Test Plan:
- Basic fire: hwag_start=1; cfg ch0 tdc=0, adv=640, dwell=1920.
  - Expect pending[0] 3 cycles after accept.
  - With output idle, commit happens at the first qualifying point.
  - ign_out[0] rises at phase=1/acnt=1280 (cyc 5120) and falls at phase=1/acnt=3200 (cyc 7040).
- Wrap arithmetic: ch1 tdc=768, adv=1000, dwell=3000.
  - Expect fire=7448 and start=4448.
  - Output high from phase=1/acnt=608 to phase=1/acnt=3608.
- Safe commit: while ign_out[0]=1, write ch0 adv=0.
  - Current dwell ends at the old fire 7040; pending[0] clears on that edge.
  - The next cycle fires at 0 (phase=0/acnt=0).
- Reject: cfg_adv=1281 or cfg_dwell=3841 -> cfg_err pulses 1 cycle; pending unchanged; cfg_ready stays 1.
- Handshake: two back-to-back valid requests -> second accepted exactly 4 cycles after the first; cfg_ready low for 3 cycles.
- Sync loss/reset:
  - hwag_start drops while ign_out[2]=1 -> ign_out[2]=0 the same cycle, and a pending ch2 commits.
  - rst asserted during CALC_START -> next cycle cfg_ready=1, pending=0, ign_out=0.
